led_pixel_rx: RTL

LED_PIXEL_RX -- requirements
Module: led_pixel_rx

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_edge_sync.sv | 61 ++++++
 rtl/led_pixel_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared state encoding, default 50 MHz timing constants and legal pixel widths
// for the LED pixel receiver.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    PASS  = 3'd3,
    STUCK = 3'd4
  } led_state_e;

  localparam int LED_T_SAMPLE_CYC = 30;
  localparam int LED_T_RESET_CYC  = 2500;
  localparam int LED_T_STUCK_CYC  = 5000;

  localparam int LED_BPP_GRB  = 24;
  localparam int LED_BPP_GRBW = 32;

endpackage

// File: rtl/led_edge_sync.sv
// Two-flop synchroniser plus rise/fall pulse generation for the serial line.
// Defining LED_GLITCH_FILTER_EN inserts a 3-sample majority filter (+2 cycles).
module led_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_serial,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic sync_q1;
  logic sync_q2;
  logic level_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_serial;
      sync_q2 <= sync_q1;
    end
  end

`ifdef LED_GLITCH_FILTER_EN
  logic hist_q1;
  logic hist_q2;
  logic filt_q;

  // Majority of the current and two previous synchronised samples; a single
  // odd sample can never win the vote.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_q1 <= 1'b0;
      hist_q2 <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist_q1 <= sync_q2;
      hist_q2 <= hist_q1;
      filt_q  <= (sync_q2 & hist_q1) | (sync_q2 & hist_q2) | (hist_q1 & hist_q2);
    end
  end

  assign o_level = filt_q;
`else
  assign o_level = sync_q2;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= o_level;
    end
  end

  assign o_rise = o_level & ~level_d;
  assign o_fall = ~o_level & level_d;

endmodule

// File: rtl/led_pixel_rx.sv
// Pulse-width LED pixel receiver: decodes PIXELS*BPP bits, forwards the rest of
// the stream, latches on a reset gap. Optional LED_GLITCH_FILTER_EN (in led_edge_sync).
module led_pixel_rx
  import led_pkg::*;
#(
  parameter int BPP          = LED_BPP_GRB,
  parameter int PIXELS       = 1,
  parameter int T_SAMPLE_CYC = LED_T_SAMPLE_CYC,
  parameter int T_RESET_CYC  = LED_T_RESET_CYC,
  parameter int T_STUCK_CYC  = LED_T_STUCK_CYC
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_serial,
  output logic                    o_serial,
  output logic [PIXELS*BPP-1:0]   o_led_data,
  output logic                    o_latch,
  output logic                    o_frame_err,
  output logic [2:0]              o_dbg_state
);

  localparam int TOTAL = PIXELS * BPP;
  localparam int CNT_W = $clog2(T_STUCK_CYC + 1);
  localparam int BIT_W = $clog2(TOTAL + 1);

  logic             level;
  logic             rise;
  logic             fall;

  led_state_e       state_q;
  led_state_e       state_d;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [TOTAL-1:0] shadow_q;
  logic             sampled_q;

  logic             shift_en;
  logic             gap_done;
  logic             stuck_hit;
  logic             frame_full;
  logic             latch_evt;
  logic             discard;

  led_edge_sync u_edge_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_serial (i_serial),
    .o_level  (level),
    .o_rise   (rise),
    .o_fall   (fall)
  );

  always_comb begin
    state_d    = state_q;
    shift_en   = 1'b0;
    latch_evt  = 1'b0;
    discard    = 1'b0;
    gap_done   = !level && (cyc_cnt_q == CNT_W'(T_RESET_CYC - 1));
    stuck_hit  = level && (cyc_cnt_q == CNT_W'(T_STUCK_CYC - 1));
    frame_full = (bit_cnt_q == BIT_W'(TOTAL));
    case (state_q)
      IDLE: begin
        if (rise && !frame_full) state_d = HIGH;
      end
      HIGH: begin
        // An early fall carries level 0, so the same shift covers both the
        // timed sample and a short "0" pulse; sampled_q keeps it to one shift.
        if (!sampled_q && (fall || cyc_cnt_q == CNT_W'(T_SAMPLE_CYC))) shift_en = 1'b1;
        if (fall) state_d = LOW;
        else if (stuck_hit) state_d = STUCK;
      end
      LOW, PASS: begin
        if (rise) begin
          state_d = frame_full ? PASS : HIGH;
        end else if (gap_done) begin
          latch_evt = 1'b1;
          state_d   = IDLE;
        end else if (stuck_hit) begin
          state_d = STUCK;
        end
      end
      STUCK: begin
        if (gap_done) begin
          discard = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      sampled_q   <= 1'b0;
      o_led_data  <= '0;
      o_serial    <= 1'b0;
      o_latch     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q <= state_d;

      if (rise || fall) cyc_cnt_q <= '0;
      else if (cyc_cnt_q != CNT_W'(T_STUCK_CYC)) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);

      if (rise) sampled_q <= 1'b0;
      else if (shift_en) sampled_q <= 1'b1;

      if (latch_evt || discard) begin
        bit_cnt_q <= '0;
        shadow_q  <= '0;
      end else if (shift_en) begin
        shadow_q  <= {shadow_q[TOTAL-2:0], level};
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end

      o_latch <= latch_evt && frame_full;
      if (latch_evt && frame_full) o_led_data <= shadow_q;

      if (latch_evt && frame_full) o_frame_err <= 1'b0;
      else if (latch_evt && bit_cnt_q != '0) o_frame_err <= 1'b1;
      else if (state_d == STUCK && state_q != STUCK) o_frame_err <= 1'b1;

      // Look at the next state so the first forwarded pulse is not clipped.
      o_serial <= (state_d == PASS) && level;
    end
  end

  assign o_dbg_state = state_q;

endmodule
